// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared constants for the multi-port register file
// Holds the named register indices (fp, sp, first general register) and the
// default geometry used by cpu_regfile_mp and cpu_regfile_scoreboard.
package cpu_regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam int DEFAULT_NUM_RD   = 2;

    localparam int REG_FP = 0;
    localparam int REG_SP = 1;
    localparam int REG_R0 = 2;

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// rtl/cpu_regfile_scoreboard.sv - per-register busy bits with reserve/clear priority
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   write_enable_i        write strobe; clears busy of write_index_i
//   write_index_i         register being written
//   reserve_i             reserve strobe; sets busy of reserve_index_i
//   reserve_index_i       register being reserved
//   busy_o                registered busy bit per register
//   read_busy_o           busy view used by the read ports: the post-edge
//                         value when FWD_BUSY=1, the current value otherwise
module cpu_regfile_scoreboard
    import cpu_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter bit FWD_BUSY = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                write_enable_i,
    input  logic [IDX_W-1:0]    write_index_i,
    input  logic                reserve_i,
    input  logic [IDX_W-1:0]    reserve_index_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [NUM_REGS-1:0] read_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    // Reserve beats a same-cycle write-clear: the new producer is still pending.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
        assign busy_next[g] = (reserve_i && reserve_index_i == IDX_W'(g)) ? 1'b1 :
                              (write_enable_i && write_index_i == IDX_W'(g)) ? 1'b0 :
                              busy_q[g];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_o      = busy_q;
    assign read_busy_o = FWD_BUSY ? busy_next : busy_q;

endmodule

// File: rtl/cpu_regfile_mp.sv
// rtl/cpu_regfile_mp.sv - multi-read-port register file with reservation scoreboard
// Optional feature macro: CPU_REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   write_enable_i        write strobe
//   reg_write_index_i     write target index
//   value_i               write data
//   read_enable_i         read strobe shared by all ports
//   reg_read_index_i      packed read indices, port p in slice p
//   value_o               packed registered read data, port p in slice p
//   valid_o               per port: read source was not reserved
//   reserve_i             mark reserve_index_i as having a pending producer
//   reserve_index_i       register to reserve
//   busy_o                scoreboard bit per register
module cpu_regfile_mp
    import cpu_regfile_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    parameter  int NUM_RD   = DEFAULT_NUM_RD,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     write_enable_i,
    input  logic [IDX_W-1:0]         reg_write_index_i,
    input  logic [DATA_W-1:0]        value_i,
    input  logic                     read_enable_i,
    input  logic [NUM_RD*IDX_W-1:0]  reg_read_index_i,
    output logic [NUM_RD*DATA_W-1:0] value_o,
    output logic [NUM_RD-1:0]        valid_o,
    input  logic                     reserve_i,
    input  logic [IDX_W-1:0]         reserve_index_i,
    output logic [NUM_REGS-1:0]      busy_o
);

`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] read_busy;

    cpu_regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .FWD_BUSY (BYPASS)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .write_enable_i  (write_enable_i),
        .write_index_i   (reg_write_index_i),
        .reserve_i       (reserve_i),
        .reserve_index_i (reserve_index_i),
        .busy_o          (busy_o),
        .read_busy_o     (read_busy)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                q <= '0;
            end else if (write_enable_i && reg_write_index_i == IDX_W'(g)) begin
                q <= value_i;
            end
        end

        assign regs[g] = q;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] rd_data;
        logic [DATA_W-1:0] val_q;
        logic              vld_q;

        assign idx = reg_read_index_i[p*IDX_W +: IDX_W];

`ifdef CPU_REGFILE_BYPASS_EN
        // A same-edge write to the read index is forwarded so the port sees
        // the value the register will hold after this edge.
        assign rd_data = (write_enable_i && reg_write_index_i == idx) ? value_i : regs[idx];
`else
        assign rd_data = regs[idx];
`endif

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                val_q <= '0;
                vld_q <= 1'b0;
            end else if (read_enable_i) begin
                val_q <= rd_data;
                vld_q <= ~read_busy[idx];
            end
        end

        assign value_o[p*DATA_W +: DATA_W] = val_q;
        assign valid_o[p]                  = vld_q;
    end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// tb/tb_cpu_regfile_mp.sv - scoreboard testbench for cpu_regfile_mp
module tb_cpu_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        write_enable_i;
    logic [3:0]  reg_write_index_i;
    logic [31:0] value_i;
    logic        read_enable_i;
    logic [7:0]  reg_read_index_i;
    logic [63:0] value_o;
    logic [1:0]  valid_o;
    logic        reserve_i;
    logic [3:0]  reserve_index_i;
    logic [15:0] busy_o;

    cpu_regfile_mp dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .write_enable_i    (write_enable_i),
        .reg_write_index_i (reg_write_index_i),
        .value_i           (value_i),
        .read_enable_i     (read_enable_i),
        .reg_read_index_i  (reg_read_index_i),
        .value_o           (value_o),
        .valid_o           (valid_o),
        .reserve_i         (reserve_i),
        .reserve_index_i   (reserve_index_i),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef CPU_REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_7 = 32'hA5A5A5A5;
`else
    localparam logic [31:0] SAME_CYCLE_7 = 32'h0;
`endif

    typedef struct {
        logic [63:0] val;
        logic [1:0]  vld;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic rd_pending = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, expv);
        end
    endtask

    // A read issued at an edge produces output for the monitor after that edge.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rd_pending <= 1'b0;
        else        rd_pending <= read_enable_i;
    end

    always @(negedge clk_i) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor_unexpected: got value=%h valid=%b expected=no read", value_o, valid_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_value", value_o, e.val);
                chk("rd_valid", {62'd0, valid_o}, {62'd0, e.vld});
            end
        end
    end

    task automatic issue_read(input logic [3:0] i1, input logic [3:0] i0,
                              input logic [31:0] e1, input logic [31:0] e0,
                              input logic [1:0] v);
        exp_t e;
        read_enable_i    = 1'b1;
        reg_read_index_i = {i1, i0};
        e.val = {e1, e0};
        e.vld = v;
        exp_q.push_back(e);
    endtask

    task automatic issue_write(input logic [3:0] idx, input logic [31:0] d);
        write_enable_i    = 1'b1;
        reg_write_index_i = idx;
        value_i           = d;
    endtask

    task automatic issue_reserve(input logic [3:0] idx);
        reserve_i       = 1'b1;
        reserve_index_i = idx;
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
        write_enable_i = 1'b0;
        read_enable_i  = 1'b0;
        reserve_i      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i             = 1'b0;
        write_enable_i    = 1'b0;
        reg_write_index_i = '0;
        value_i           = '0;
        read_enable_i     = 1'b0;
        reg_read_index_i  = '0;
        reserve_i         = 1'b0;
        reserve_index_i   = '0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_value", value_o, 64'd0);
        chk("reset_valid", {62'd0, valid_o}, 64'd0);
        chk("reset_busy", {48'd0, busy_o}, 64'd0);
        rst_i = 1'b1;

        // every register reads zero and valid after reset
        for (int r = 0; r < 16; r += 2) begin
            issue_read(4'(r + 1), 4'(r), 32'h0, 32'h0, 2'b11);
            cyc();
        end

        // write then read on both ports
        issue_write(4'd5, 32'hDEADBEEF);
        cyc();
        issue_read(4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11);
        cyc();

        // reserve makes reads stale until the producer writes
        issue_reserve(4'd3);
        cyc();
        chk("busy_after_reserve3", {48'd0, busy_o}, 64'h0008);
        issue_read(4'd3, 4'd3, 32'h0, 32'h0, 2'b00);
        cyc();
        issue_write(4'd3, 32'h12);
        cyc();
        issue_read(4'd3, 4'd3, 32'h12, 32'h12, 2'b11);
        cyc();

        // same-cycle write and read of index 7
        issue_write(4'd7, 32'hA5A5A5A5);
        issue_read(4'd5, 4'd7, 32'hDEADBEEF, SAME_CYCLE_7, 2'b11);
        cyc();
        issue_read(4'd7, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11);
        cyc();

        // same-cycle reserve and write: reserve wins, data still lands
        issue_reserve(4'd9);
        issue_write(4'd9, 32'h99);
        cyc();
        chk("busy_reserve_write9", {48'd0, busy_o}, 64'h0200);
        issue_read(4'd9, 4'd9, 32'h99, 32'h99, 2'b00);
        cyc();

        // fp and sp are ordinary registers
        issue_write(4'd0, 32'h11);
        cyc();
        issue_write(4'd1, 32'h22);
        cyc();
        issue_read(4'd1, 4'd0, 32'h22, 32'h11, 2'b11);
        cyc();

        // outputs hold while read_enable_i is low
        reg_read_index_i = {4'd5, 4'd5};
        cyc();
        cyc();
        chk("hold_value", value_o, {32'h22, 32'h11});
        chk("hold_valid", {62'd0, valid_o}, 64'd3);

        issue_write(4'd9, 32'h5);
        cyc();
        chk("busy_cleared9", {48'd0, busy_o}, 64'd0);

        // asynchronous reset with busy and read data nonzero
        issue_reserve(4'd4);
        cyc();
        chk("busy_reserve4", {48'd0, busy_o}, 64'h0010);
        issue_read(4'd5, 4'd4, 32'hDEADBEEF, 32'h0, 2'b10);
        cyc();
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_busy", {48'd0, busy_o}, 64'd0);
        chk("async_rst_value", value_o, 64'd0);
        chk("async_rst_valid", {62'd0, valid_o}, 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // first edge after release works and registers were cleared
        issue_read(4'd5, 4'd2, 32'h0, 32'h0, 2'b11);
        cyc();
        cyc();
        cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
